xnor_popcount_datapath: RTL and testbench

- Datapath side of the binarized-convolution compute handshake: executes the controller's 4-bit phase commands and answers with 4 registered status flags.
- Per transaction: fetches one activation word and one weight word from input SRAMs, XNORs them, popcounts the result over several cycles, and presents the count to the output SRAM.
- Sits between the compute controller FSM and the activation, weight and output SRAM ports.

---
 rtl/xnor_popcount_datapath_pkg.sv | 26 ++
 rtl/xnor_popcount_datapath_popcount_slice.sv | 17 +
 rtl/xnor_popcount_datapath.sv | 155 +++++++++++++++
 tb/tb_xnor_popcount_datapath.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/xnor_popcount_datapath_pkg.sv
// Shared command/status bit indices and datapath state encoding for the
// binarized-convolution XNOR/popcount handshake.
package xnor_popcount_datapath_pkg;

    localparam int CMD_GET_ADDR = 3;
    localparam int CMD_GET_DATA = 2;
    localparam int CMD_COUNT    = 1;
    localparam int CMD_WRITE    = 0;

    localparam int ST_GOT_DATA   = 3;
    localparam int ST_READY_RX   = 2;
    localparam int ST_COUNT_DONE = 1;
    localparam int ST_WRITTEN    = 0;

    typedef enum logic [2:0] {
        D_IDLE,
        D_FETCH,
        D_CAPT,
        D_READY,
        D_XNOR,
        D_COUNT,
        D_CDONE,
        D_WRITE
    } d_state_e;

endpackage

// File: rtl/xnor_popcount_datapath_popcount_slice.sv
// Combinational popcount of one POP_W-bit chunk of the XNOR word.
module popcount_slice #(
    parameter int POP_W = 8,
    parameter int OUT_W = $clog2(POP_W) + 1
) (
    input  logic [POP_W-1:0] in_bits,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < POP_W; i++) begin
            count = count + OUT_W'(in_bits[i]);
        end
    end

endmodule

// File: rtl/xnor_popcount_datapath.sv
// Datapath half of the compute handshake: fetch act/weight words, XNOR them,
// popcount POP_W bits per cycle and present the result to the output SRAM.
module xnor_popcount_datapath
    import xnor_popcount_datapath_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int POP_W  = 8,
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    output logic [3:0]        status,
    input  logic              idx_clr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] act_rdata,
    input  logic [DATA_W-1:0] wt_rdata,
    output logic [ADDR_W-1:0] out_addr,
    output logic [CNT_W-1:0]  out_wdata,
    output logic              frame_done
);

    localparam int NCHUNK = DATA_W / POP_W;
    localparam int CH_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int PC_W   = $clog2(POP_W) + 1;

    d_state_e          state_q, state_d;
    logic [3:0]        status_q, status_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] act_q, act_d, wt_q, wt_d, xnor_q, xnor_d;
    logic [CNT_W-1:0]  acc_q, acc_d, out_wdata_q, out_wdata_d;
    logic [CH_W-1:0]   chunk_q, chunk_d;
    logic              frame_done_q, frame_done_d;

    logic [POP_W-1:0]  slice;
    logic [PC_W-1:0]   pop;
    logic [CNT_W-1:0]  acc_sum;
    logic              last_chunk;

    assign slice      = xnor_q[chunk_q*POP_W +: POP_W];
    assign last_chunk = (chunk_q == CH_W'(NCHUNK - 1));
    assign acc_sum    = acc_q + CNT_W'(pop);

    popcount_slice #(.POP_W(POP_W), .OUT_W(PC_W)) u_pop (
        .in_bits (slice),
        .count   (pop)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        act_d        = act_q;
        wt_d         = wt_q;
        xnor_d       = xnor_q;
        acc_d        = acc_q;
        chunk_d      = chunk_q;
        out_wdata_d  = out_wdata_q;
        rd_en_d      = 1'b0;
        frame_done_d = 1'b0;
        case (state_q)
            D_IDLE: begin
                // a clear wins; the held get_address starts the fetch next cycle
                if (idx_clr) begin
                    idx_d = '0;
                end else if (cmd[CMD_GET_ADDR]) begin
                    rd_en_d = 1'b1;
                    state_d = D_FETCH;
                end
            end
            D_FETCH: state_d = D_CAPT;
            D_CAPT: begin
                act_d   = act_rdata;
                wt_d    = wt_rdata;
                state_d = D_READY;
            end
            D_READY: begin
                if (cmd[CMD_GET_DATA] && !cmd[CMD_GET_ADDR]) begin
                    xnor_d  = ~(act_q ^ wt_q);
                    state_d = D_XNOR;
                end
            end
            D_XNOR: begin
                if (cmd[CMD_COUNT]) begin
                    acc_d   = '0;
                    chunk_d = '0;
                    state_d = D_COUNT;
                end
            end
            D_COUNT: begin
                acc_d   = acc_sum;
                chunk_d = chunk_q + 1'b1;
                if (last_chunk) begin
                    out_wdata_d = acc_sum;
                    state_d     = D_CDONE;
                end
            end
            D_CDONE: if (cmd[CMD_WRITE]) state_d = D_WRITE;
            D_WRITE: begin
                // idx moves only after the controller has seen written_success
                if (status_q[ST_WRITTEN] && !cmd[CMD_WRITE]) begin
                    idx_d        = idx_q + 1'b1;
                    frame_done_d = &idx_q;
                    state_d      = D_IDLE;
                end
            end
            default: state_d = D_IDLE;
        endcase

        status_d                = '0;
        status_d[ST_READY_RX]   = (state_q == D_READY) && cmd[CMD_GET_ADDR];
        status_d[ST_GOT_DATA]   = (state_q == D_XNOR) && (state_d == D_XNOR) && cmd[CMD_GET_DATA];
        status_d[ST_COUNT_DONE] = (state_d == D_CDONE) &&
                                  ((state_q == D_COUNT) || (status_q[ST_COUNT_DONE] && cmd[CMD_COUNT]));
        status_d[ST_WRITTEN]    = (state_q == D_WRITE) && (state_d == D_WRITE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= D_IDLE;
            status_q     <= '0;
            rd_en_q      <= 1'b0;
            idx_q        <= '0;
            act_q        <= '0;
            wt_q         <= '0;
            xnor_q       <= '0;
            acc_q        <= '0;
            chunk_q      <= '0;
            out_wdata_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            status_q     <= status_d;
            rd_en_q      <= rd_en_d;
            idx_q        <= idx_d;
            act_q        <= act_d;
            wt_q         <= wt_d;
            xnor_q       <= xnor_d;
            acc_q        <= acc_d;
            chunk_q      <= chunk_d;
            out_wdata_q  <= out_wdata_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign status     = status_q;
    assign rd_en      = rd_en_q;
    assign rd_addr    = idx_q;
    assign out_addr   = idx_q;
    assign out_wdata  = out_wdata_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_xnor_popcount_datapath.sv
// Controller-side bench for xnor_popcount_datapath: SRAM models, handshake
// driver and a reference popcount computed straight from the word values.
module tb_xnor_popcount_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  cmd;
    logic [3:0]  status;
    logic        idx_clr;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [31:0] act_rdata, wt_rdata;
    logic [7:0]  out_addr;
    logic [5:0]  out_wdata;
    logic        frame_done;

    logic [31:0] act_mem [256];
    logic [31:0] wt_mem  [256];
    logic [7:0]  exp_idx;
    int          checks = 0;
    int          errors = 0;

    xnor_popcount_datapath #(.DATA_W(32), .POP_W(8), .ADDR_W(8), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .cmd(cmd), .status(status), .idx_clr(idx_clr),
        .rd_en(rd_en), .rd_addr(rd_addr), .act_rdata(act_rdata), .wt_rdata(wt_rdata),
        .out_addr(out_addr), .out_wdata(out_wdata), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) begin
            act_rdata <= act_mem[rd_addr];
            wt_rdata  <= wt_mem[rd_addr];
        end
    end

    function automatic int ref_count(input logic [31:0] a, input logic [31:0] w);
        return $countones(~(a ^ w));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full controller handshake at exp_idx; hold>0 keeps get_address high
    // for extra cycles after ready_to_receive before releasing it alone.
    task automatic run_txn(input int hold);
        int lat;
        int exp_cnt;
        exp_cnt = ref_count(act_mem[exp_idx], wt_mem[exp_idx]);
        cmd = 4'b1000;
        tick();
        checks++;
        if (rd_en !== 1'b1 || rd_addr !== exp_idx) begin
            errors++; $display("FAIL rd_strobe idx=%0d rd_en=%b rd_addr=%0d", exp_idx, rd_en, rd_addr);
        end
        tick();
        lat = 1;
        checks++;
        if (rd_en !== 1'b0) begin
            errors++; $display("FAIL rd_one_cycle idx=%0d rd_en=%b want 0", exp_idx, rd_en);
        end
        while (!status[2] && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat !== 3 || status[2] !== 1'b1) begin
            errors++; $display("FAIL ready_latency idx=%0d got %0d edges want 3", exp_idx, lat);
        end
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                tick();
                checks++;
                if (status !== 4'b0100) begin
                    errors++; $display("FAIL ready_hold cyc=%0d status=%b want 0100", i, status);
                end
            end
            cmd = 4'b0000;
            tick();
            checks++;
            if (status[2] !== 1'b0) begin
                errors++; $display("FAIL ready_fall status=%b want 0000", status);
            end
        end
        cmd = 4'b0100;
        lat = 0;
        do begin tick(); lat++; end while (!status[3] && lat < 20);
        checks++;
        if (status[3] !== 1'b1) begin
            errors++; $display("FAIL got_data_timeout idx=%0d status=%b", exp_idx, status);
        end
        cmd = 4'b0010;
        tick();
        lat = 0;
        while (!status[1] && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat !== 4 || status[1] !== 1'b1) begin
            errors++; $display("FAIL count_latency idx=%0d got %0d edges want 4", exp_idx, lat);
        end
        checks++;
        if (out_wdata !== 6'(exp_cnt)) begin
            errors++; $display("FAIL count_value idx=%0d got %0d want %0d", exp_idx, out_wdata, exp_cnt);
        end
        cmd = 4'b0001;
        lat = 0;
        do begin
            tick(); lat++;
            checks++;
            if (out_addr !== exp_idx || out_wdata !== 6'(exp_cnt)) begin
                errors++; $display("FAIL write_hold idx=%0d got addr=%0d data=%0d want %0d", exp_idx, out_addr, out_wdata, exp_cnt);
            end
        end while (!status[0] && lat < 20);
        checks++;
        if (status !== 4'b0001) begin
            errors++; $display("FAIL written_success idx=%0d status=%b want 0001", exp_idx, status);
        end
        cmd = 4'b0000;
        tick();
        checks++;
        if (out_addr !== 8'(exp_idx + 8'd1) || status !== 4'b0000 || frame_done !== (exp_idx == 8'd255)) begin
            errors++; $display("FAIL write_exit idx=%0d addr=%0d status=%b frame_done=%b", exp_idx, out_addr, status, frame_done);
        end
        tick();
        checks++;
        if (frame_done !== 1'b0) begin
            errors++; $display("FAIL frame_pulse idx=%0d frame_done=%b want 0", exp_idx, frame_done);
        end
        exp_idx = exp_idx + 8'd1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cmd = 4'hF; idx_clr = 1'b0;
        tick(); tick();
        checks++;
        if (status !== 4'b0 || rd_en !== 1'b0 || out_wdata !== 6'd0 || frame_done !== 1'b0 || out_addr !== 8'd0) begin
            errors++; $display("FAIL reset_state status=%b rd_en=%b data=%0d fd=%b addr=%0d", status, rd_en, out_wdata, frame_done, out_addr);
        end
        cmd = 4'b0000; reset = 1'b1;
        tick();
        exp_idx = 8'd0;
    endtask

    task automatic test_reset_mid_count();
        int n;
        cmd = 4'b1000;
        n = 0; do begin tick(); n++; end while (!status[2] && n < 20);
        cmd = 4'b0100;
        n = 0; do begin tick(); n++; end while (!status[3] && n < 20);
        cmd = 4'b0010;
        tick(); tick();
        reset = 1'b0; cmd = 4'b0000;
        tick();
        checks++;
        if (status !== 4'b0 || rd_en !== 1'b0 || out_wdata !== 6'd0 || out_addr !== 8'd0) begin
            errors++; $display("FAIL reset_mid_count status=%b rd_en=%b data=%0d addr=%0d", status, rd_en, out_wdata, out_addr);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (status !== 4'b0 || out_addr !== 8'd0) begin
            errors++; $display("FAIL reset_release status=%b addr=%0d", status, out_addr);
        end
    endtask

    task automatic test_single();
        act_mem[0] = 32'hFFFF0000; wt_mem[0] = 32'hFFFFFFFF;
        run_txn(0);
    endtask

    task automatic test_extremes();
        act_mem[1] = 32'hA5A5A5A5; wt_mem[1] = 32'hA5A5A5A5;
        act_mem[2] = 32'h00000000; wt_mem[2] = 32'hFFFFFFFF;
        run_txn(0);
        run_txn(0);
    endtask

    task automatic test_latency_hold();
        repeat (3) tick();
        run_txn(5);
    endtask

    task automatic test_wrap();
        do run_txn(0); while (exp_idx != 8'd0);
        checks++;
        if (out_addr !== 8'd0) begin
            errors++; $display("FAIL wrap_idx addr=%0d want 0", out_addr);
        end
    endtask

    task automatic test_idx_clr();
        repeat (7) run_txn(0);
        checks++;
        if (out_addr !== 8'd7) begin
            errors++; $display("FAIL pre_clr_idx addr=%0d want 7", out_addr);
        end
        idx_clr = 1'b1; cmd = 4'b1000;
        tick();
        idx_clr = 1'b0;
        exp_idx = 8'd0;
        run_txn(0);
        checks++;
        if (out_addr !== 8'd1) begin
            errors++; $display("FAIL post_clr_idx addr=%0d want 1", out_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            act_mem[i] = $urandom();
            wt_mem[i]  = $urandom();
        end
        act_rdata = '0; wt_rdata = '0;
        test_reset();
        test_reset_mid_count();
        test_single();
        test_extremes();
        test_latency_hold();
        test_wrap();
        test_idx_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
